program_sequencer_fetch: RTL and testbench

// Front end of the 4-bit microprocessor: fetches 8-bit instructions from the slow program ROM over a
// req/valid handshake, holds them in the IR, and decodes each one into the control word of the

---
 rtl/program_sequencer_fetch.sv | 134 +++++++++++++
 tb/tb_program_sequencer_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer_fetch.sv
// Instruction fetch/decode front end: ROM handshake with timeout retry, IR, PC and jump control,
// and decode of the IR into the computational unit's control word.
module program_sequencer_fetch #(
    parameter int PC_W        = 8,
    parameter int ROM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            sync_reset,
    output logic [PC_W-1:0] rom_addr,
    output logic            rom_req,
    input  logic            rom_valid,
    input  logic [7:0]      rom_data,
    input  logic            r_eq_0,
    output logic [3:0]      source_sel,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic [3:0]      nibble_ir,
    output logic [PC_W-1:0] pc,
    output logic            rom_err
);

    localparam int CNT_W = $clog2(ROM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_RETRY = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [7:0]        ir_reg, ir_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              rom_err_reg, rom_err_next;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_reg   <= S_FETCH;
            pc_reg      <= '0;
            ir_reg      <= 8'h00;
            cnt_reg     <= '0;
            rom_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            cnt_reg     <= cnt_next;
            rom_err_reg <= rom_err_next;
        end
    end

    // Instruction class decode
    logic       is_load, is_move, is_alu, is_jmp, is_jnz, has_dest;
    logic [2:0] dest, src;
    logic       move_pins, dm_access;
    logic [7:0] dest_hot;
    logic [8:0] ctrl_word;

    assign is_load   = ~ir_reg[7];
    assign is_move   = (ir_reg[7:6] == 2'b10);
    assign is_alu    = (ir_reg[7:5] == 3'b110);
    assign is_jmp    = (ir_reg[7:4] == 4'b1110);
    assign is_jnz    = (ir_reg[7:4] == 4'b1111);
    assign has_dest  = is_load | is_move;
    assign dest      = is_load ? ir_reg[6:4] : ir_reg[5:3];
    assign src       = ir_reg[2:0];
    assign move_pins = is_move && (src == dest);

    // A move whose source equals its destination reads i_pins, so it is not a dm read.
    assign dm_access = has_dest && ((dest == 3'd7) || (is_move && !move_pins && (src == 3'd7)));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dest
            assign dest_hot[gi] = has_dest && (dest == 3'(gi));
        end
    endgenerate

    always_comb begin
        source_sel = 4'd0;
        if (is_load)
            source_sel = 4'd8;
        else if (is_move)
            source_sel = move_pins ? 4'd9 : {1'b0, src};
    end

    assign i_sel     = dm_access && (dest != 3'd6);
    assign x_sel     = is_alu & ir_reg[4];
    assign y_sel     = is_alu & ir_reg[3];
    assign nibble_ir = ir_reg[3:0];

    assign ctrl_word = {dest_hot[4], dest_hot[7], dest_hot[6] | i_sel, dest_hot[5],
                        is_alu, dest_hot[3:0]};

    assign reg_en   = (state_reg == S_EXEC && !sync_reset) ? ctrl_word : 9'h000;
    assign rom_req  = (state_reg == S_FETCH) && !sync_reset;
    assign rom_addr = pc_reg;
    assign pc       = pc_reg;
    assign rom_err  = rom_err_reg;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        cnt_next     = cnt_reg;
        rom_err_next = rom_err_reg;
        case (state_reg)
            S_FETCH: begin
                if (rom_valid) begin
                    ir_next    = rom_data;
                    cnt_next   = '0;
                    state_next = S_EXEC;
                end else if (cnt_reg == CNT_W'(ROM_TIMEOUT - 1)) begin
                    cnt_next     = '0;
                    rom_err_next = 1'b1;
                    state_next   = S_RETRY;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_EXEC: begin
                state_next = S_FETCH;
                if (is_jmp || (is_jnz && !r_eq_0))
                    pc_next = {pc_reg[PC_W-1:4], ir_reg[3:0]};
                else
                    pc_next = pc_reg + PC_W'(1);
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_program_sequencer_fetch.sv
// Scoreboard bench: a ROM responder issues instructions and queues the expected decode and
// next PC; a monitor checks each EXEC cycle and the PC that follows it.
module tb_program_sequencer_fetch;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       sync_reset, rom_valid, r_eq_0;
    logic [7:0] rom_data;
    logic [7:0] rom_addr, pc;
    logic       rom_req, i_sel, x_sel, y_sel, rom_err;
    logic [3:0] source_sel, nibble_ir;
    logic [8:0] reg_en;

    program_sequencer_fetch #(.PC_W(8), .ROM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .sync_reset(sync_reset), .rom_addr(rom_addr), .rom_req(rom_req),
        .rom_valid(rom_valid), .rom_data(rom_data), .r_eq_0(r_eq_0),
        .source_sel(source_sel), .reg_en(reg_en), .i_sel(i_sel), .x_sel(x_sel),
        .y_sel(y_sel), .nibble_ir(nibble_ir), .pc(pc), .rom_err(rom_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ir;
        logic [8:0] en;
        logic [3:0] src;
        logic       isel, x, y, err;
        logic [7:0] next_pc;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mpc      = 8'h00;
    logic       m_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: destination number -> reg_en bit
    function automatic exp_t model(input logic [7:0] ir, input logic [7:0] cur_pc, input logic r);
        int   dmap[8] = '{0, 1, 2, 3, 8, 5, 6, 7};
        exp_t e;
        int   d, s;
        bit   has, dm;
        e.ir = ir; e.addr = cur_pc; e.en = '0; e.src = 0; e.isel = 0; e.x = 0; e.y = 0;
        e.err = 0; e.next_pc = cur_pc + 8'd1;
        has = 0; dm = 0; d = 0;
        if (ir[7] == 1'b0) begin
            d = int'(ir[6:4]); has = 1; e.src = 8; dm = (d == 7);
        end else if (ir[7:6] == 2'b10) begin
            d = int'(ir[5:3]); s = int'(ir[2:0]); has = 1;
            e.src = (s == d) ? 4'd9 : 4'(s);
            dm = (d == 7) || (s == 7 && s != d);
        end else if (ir[7:5] == 3'b110) begin
            e.x = ir[4]; e.y = ir[3]; e.en[4] = 1'b1;
        end else if (ir[4] == 1'b0 || r == 1'b0) begin
            e.next_pc = {cur_pc[7:4], ir[3:0]};
        end
        if (has) begin
            e.en[dmap[d]] = 1'b1;
            if (dm && d != 6) begin
                e.en[6] = 1'b1; e.isel = 1'b1;
            end
        end
        return e;
    endfunction

    // Monitor
    bit         exec_next = 0;
    bit         pc_pending = 0;
    logic [7:0] pc_exp;
    always @(negedge clk) begin
        exp_t e;
        if (pc_pending) begin
            chk("pc_after_exec", 32'(pc), 32'(pc_exp));
            pc_pending = 0;
        end
        if (exec_next) begin
            exec_next = 0;
            if (q.size() == 0) begin
                chk("exec_without_expected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                $display("txn addr=%02h ir=%02h reg_en=%03h src=%0d i_sel=%0b x=%0b y=%0b",
                         e.addr, e.ir, reg_en, source_sel, i_sel, x_sel, y_sel);
                chk("reg_en", 32'(reg_en), 32'(e.en));
                chk("source_sel", 32'(source_sel), 32'(e.src));
                chk("i_sel", 32'(i_sel), 32'(e.isel));
                chk("x_y_sel", 32'({x_sel, y_sel}), 32'({e.x, e.y}));
                chk("nibble_ir", 32'(nibble_ir), 32'(e.ir[3:0]));
                chk("rom_err", 32'(rom_err), 32'(e.err));
                pc_exp = e.next_pc;
                pc_pending = 1;
            end
        end else if (reg_en !== 9'h000) begin
            chk("reg_en_idle", 32'(reg_en), 32'd0);
        end
        if (rom_req && rom_valid && !sync_reset) begin
            if (q.size() == 0)
                chk("accept_without_expected", 32'd1, 32'd0);
            else
                chk("rom_addr", 32'(rom_addr), 32'(q[0].addr));
            exec_next = 1;
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!rom_req && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!rom_req) begin
            $display("FAIL wait_rom_req: got no rom_req, expected rom_req within 100 cycles");
            n_checks++; n_fail++;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "rom_req never asserted");
        end
    endtask

    task automatic issue(input logic [7:0] d, input logic r, input int dly);
        exp_t e;
        wait_req();
        repeat (dly) begin @(posedge clk); #1; end
        e = model(d, mpc, r);
        e.err = m_err;
        q.push_back(e);
        mpc = e.next_pc;
        rom_data = d; rom_valid = 1'b1; r_eq_0 = r;
        @(posedge clk); #1;
        rom_valid = 1'b0; rom_data = 8'($urandom);
    endtask

    function automatic logic [7:0] rand_nonjump();
        logic [7:0] d = 8'($urandom);
        if (d[7:5] == 3'b111) d[5] = 1'b0;
        return d;
    endfunction

    initial begin
        int n;
        logic [7:0] addr0;
        sync_reset = 1'b1; rom_valid = 1'b0; rom_data = 8'h00; r_eq_0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rom_req", 32'(rom_req), 32'd0);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_rom_err", 32'(rom_err), 32'd0);
        sync_reset = 1'b0;

        issue(8'h35, 1'b0, 3);
        issue(8'hA3, 1'b0, 0);
        issue(8'h9B, 1'b0, 1);
        issue(8'h87, 1'b0, 0);
        issue(8'hB6, 1'b0, 2);
        for (int i = 0; i < 60; i++)
            issue(8'($urandom), 1'($urandom), int'($urandom_range(0, 4)));

        // Withhold rom_valid for a full timeout window
        wait_req();
        addr0 = rom_addr;
        n = 0;
        while (rom_req && n < 40) begin
            n++; @(posedge clk); #1;
        end
        chk("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
        @(posedge clk); #1;
        chk("retry_req_back", 32'(rom_req), 32'd1);
        chk("retry_same_addr", 32'(rom_addr), 32'(addr0));
        chk("retry_rom_err", 32'(rom_err), 32'd1);
        m_err = 1'b1;

        while (mpc != 8'h2C) issue(rand_nonjump(), 1'($urandom), int'($urandom_range(0, 2)));
        issue(8'hF3, 1'b0, 0);
        while (mpc != 8'h2C) issue(rand_nonjump(), 1'($urandom), 0);
        issue(8'hF3, 1'b1, 1);
        while (mpc != 8'hFF) issue(rand_nonjump(), 1'($urandom), int'($urandom_range(0, 1)));
        issue(8'hE0, 1'b0, 0);
        for (int i = 0; i < 40; i++)
            issue(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-fetch with rom_valid in the same cycle
        wait_req();
        rom_valid = 1'b1; rom_data = 8'hFF; sync_reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_pc", 32'(pc), 32'd0);
        chk("rst_mid_reg_en", 32'(reg_en), 32'd0);
        chk("rst_mid_rom_req", 32'(rom_req), 32'd0);
        chk("rst_mid_rom_err", 32'(rom_err), 32'd0);
        rom_valid = 1'b0; sync_reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ir_nibble", 32'(nibble_ir), 32'd0);
        chk("rst_mid_ir_src", 32'(source_sel), 32'd8);
        mpc = 8'h00; m_err = 1'b0;
        issue(8'h35, 1'b0, 0);
        issue(8'hF3, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
